// File: rtl/vec_mem_strided_if.sv
// rtl/vec_mem_strided_if.sv - request/response bus for the strided vector memory
interface vec_mem_strided_if #(
    parameter int WORD_W = 32,
    parameter int LANES  = 16,
    parameter int ADDR_W = 9
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [ADDR_W-1:0]         req_addr;
    logic [ADDR_W-1:0]         req_stride;
    logic [LANES-1:0]          req_mask;
    logic [LANES*WORD_W-1:0]   req_wdata;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [LANES*WORD_W-1:0]   rsp_rdata;
    logic [LANES-1:0]          rsp_lane_ok;
    logic                      rsp_err;
    logic                      init_done;

    modport master (
        output req_valid, req_we, req_addr, req_stride, req_mask, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_lane_ok, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_stride, req_mask, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_lane_ok, rsp_err, init_done
    );
endinterface

// File: rtl/vec_mem_strided.sv
// rtl/vec_mem_strided.sv - parametrised vector memory with strided gather/scatter and lane masks
module vec_mem_strided #(
    parameter int WORD_W = 32,
    parameter int LANES  = 16,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    vec_mem_strided_if.slave bus
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW = ADDR_W + LW + 1;
    localparam int MW = $clog2(DEPTH);
    localparam int NB = DEPTH / LANES;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic                    r_rsp_valid;
    logic [LANES*WORD_W-1:0] r_rdata;
    logic [LANES-1:0]        r_lane_ok;
    logic                    r_err;
    logic                    r_init_done;
    logic [WORD_W-1:0]       r_mem [DEPTH];

    logic [AW-1:0]           w_addr [LANES];
    logic [LANES-1:0]        w_inrange;
    logic [LANES-1:0]        w_ok;
    logic                    w_accept;

    // Lane addresses are kept wide enough that base + i*stride never wraps back into range.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_addr[i]    = AW'(bus.req_addr) + AW'(i) * AW'(bus.req_stride);
            w_inrange[i] = w_addr[i] < AW'(DEPTH);
        end
    end

    assign w_ok          = bus.req_mask & w_inrange;
    assign bus.req_ready = !reset && (r_state == RUN) && (!r_rsp_valid || bus.rsp_ready);
    assign w_accept      = bus.req_valid && bus.req_ready;

    // Ascending lane loop makes the highest-index lane win on shared addresses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == INIT) begin
                for (int j = 0; j < LANES; j++) begin
                    r_mem[MW'(int'(r_cnt) * LANES + j)] <= '0;
                end
            end else if (w_accept && bus.req_we) begin
                for (int i = 0; i < LANES; i++) begin
                    if (w_ok[i]) begin
                        r_mem[w_addr[i][MW-1:0]] <= bus.req_wdata[WORD_W*i +: WORD_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= INIT;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_lane_ok   <= '0;
            r_err       <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(NB - 1)) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_rsp_valid <= 1'b1;
                        r_lane_ok   <= w_ok;
                        r_err       <= |(bus.req_mask & ~w_inrange);
                        for (int i = 0; i < LANES; i++) begin
                            r_rdata[WORD_W*i +: WORD_W] <= (!bus.req_we && w_ok[i]) ?
                                r_mem[w_addr[i][MW-1:0]] : '0;
                        end
                    end else if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rdata;
    assign bus.rsp_lane_ok = r_lane_ok;
    assign bus.rsp_err     = r_err;
    assign bus.init_done   = r_init_done;
endmodule

// File: tb/tb_vec_mem_strided.sv
// tb/tb_vec_mem_strided.sv - bench for vec_mem_strided with a behavioural reference model
module tb_vec_mem_strided;
    localparam int WORD_W = 32;
    localparam int LANES  = 16;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int DW     = LANES * WORD_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vec_mem_strided_if #(.WORD_W(WORD_W), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();

    vec_mem_strided #(.WORD_W(WORD_W), .LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: whole-array view, one request per accepting edge.
    logic [WORD_W-1:0] m_mem [DEPTH];
    bit                m_valid = 0;
    bit                m_done  = 0;
    int                m_cnt   = 0;
    logic [DW-1:0]     m_rdata = '0;
    logic [LANES-1:0]  m_ok    = '0;
    bit                m_err   = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_valid = 0; m_done = 0; m_cnt = 0;
                m_rdata = '0; m_ok = '0; m_err = 0;
            end else if (!m_done) begin
                m_cnt++;
                if (m_cnt == DEPTH / LANES) begin
                    m_done = 1;
                    for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
                end
            end else if (bus.req_valid && (!m_valid || bus.rsp_ready)) begin
                int a [LANES];
                m_ok = '0; m_err = 0; m_rdata = '0;
                for (int i = 0; i < LANES; i++) begin
                    a[i] = int'(bus.req_addr) + i * int'(bus.req_stride);
                    if (bus.req_mask[i]) begin
                        if (a[i] < DEPTH) m_ok[i] = 1'b1;
                        else m_err = 1;
                    end
                end
                for (int i = 0; i < LANES; i++) begin
                    if (m_ok[i]) begin
                        if (bus.req_we) m_mem[a[i]] = bus.req_wdata[WORD_W*i +: WORD_W];
                        else m_rdata[WORD_W*i +: WORD_W] = m_mem[a[i]];
                    end
                end
                m_valid = 1;
            end else if (bus.rsp_ready) begin
                m_valid = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("req_ready", DW'(bus.req_ready), DW'(!reset && m_done && (!m_valid || bus.rsp_ready)));
            check("rsp_valid", DW'(bus.rsp_valid), DW'(m_valid));
            check("init_done", DW'(bus.init_done), DW'(m_done));
            if (m_valid) begin
                check("rsp_rdata", bus.rsp_rdata, m_rdata);
                check("rsp_lane_ok", DW'(bus.rsp_lane_ok), DW'(m_ok));
                check("rsp_err", DW'(bus.rsp_err), DW'(m_err));
            end
        end
    end

    task automatic do_req(input bit we, input int addr, input int stride, input logic [LANES-1:0] mask,
                          input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                          output logic [LANES-1:0] ok, output logic er);
        int n = 0;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = ADDR_W'(addr);
        bus.req_stride = ADDR_W'(stride);
        bus.req_mask   = mask;
        bus.req_wdata  = wd;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("req_timeout", DW'(0), DW'(1));
            bus.req_valid = 1'b0;
            rd = '0; ok = '0; er = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            check("rsp_latency", DW'(bus.rsp_valid), DW'(1));
            rd = bus.rsp_rdata;
            ok = bus.rsp_lane_ok;
            er = bus.rsp_err;
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic wait_init(input string name);
        int cyc = 0;
        while (!bus.init_done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check(name, DW'(cyc), DW'(32));
    endtask

    logic [DW-1:0]    rd, wd;
    logic [LANES-1:0] ok;
    logic             er;
    logic [DW-1:0]    held;
    time              t0;

    initial begin
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_stride = '0;
        bus.req_mask = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        check("rst_rdata", bus.rsp_rdata, '0);
        reset = 1'b0;
        wait_init("init_latency");

        do_req(0, 0, 1, 16'hFFFF, '0, rd, ok, er);
        check("clear_rdata", rd, '0);
        check("clear_ok", DW'(ok), DW'(16'hFFFF));
        check("clear_err", DW'(er), DW'(0));

        for (int i = 0; i < LANES; i++) wd[WORD_W*i +: WORD_W] = 32'(2000 + i);
        t0 = $time;
        do_req(1, 0, 1, 16'hFFFF, wd, rd, ok, er);
        check("wr_rdata_zero", rd, '0);
        do_req(0, 0, 1, 16'hFFFF, '0, rd, ok, er);
        check("back_to_back_time", DW'($time - t0), DW'(20));
        for (int i = 0; i < LANES; i++) check("rb_lane", DW'(rd[WORD_W*i +: WORD_W]), DW'(2000 + i));

        for (int i = 0; i < LANES; i++) wd[WORD_W*i +: WORD_W] = 32'(i);
        do_req(1, 8, 4, 16'h00FF, wd, rd, ok, er);
        check("stride_wr_ok", DW'(ok), DW'(16'h00FF));
        do_req(0, 8, 4, 16'hFFFF, '0, rd, ok, er);
        for (int i = 0; i < LANES; i++) check("stride_lane", DW'(rd[WORD_W*i +: WORD_W]), DW'(i < 8 ? i : 0));
        check("stride_ok", DW'(ok), DW'(16'hFFFF));

        do_req(0, 500, 1, 16'hFFFF, '0, rd, ok, er);
        check("oor_ok", DW'(ok), DW'(16'h0FFF));
        check("oor_err", DW'(er), DW'(1));
        check("oor_hi_lanes", DW'(rd[DW-1 -: 4*WORD_W]), '0);
        for (int i = 0; i < LANES; i++) wd[WORD_W*i +: WORD_W] = 32'hDEAD0000 | 32'(i);
        do_req(1, 500, 1, 16'hFFFF, wd, rd, ok, er);
        check("oor_wr_err", DW'(er), DW'(1));
        do_req(0, 0, 1, 16'h000F, '0, rd, ok, er);
        for (int i = 0; i < 4; i++) check("no_alias", DW'(rd[WORD_W*i +: WORD_W]), DW'(2000 + i));

        do_req(0, 0, 0, 16'h0000, '0, rd, ok, er);
        check("nomask_ok", DW'(ok), DW'(0));
        check("nomask_err", DW'(er), DW'(0));

        for (int i = 0; i < LANES; i++) wd[WORD_W*i +: WORD_W] = 32'(100 + i);
        do_req(1, 7, 0, 16'hFFFF, wd, rd, ok, er);
        do_req(0, 7, 0, 16'h0001, '0, rd, ok, er);
        check("stride0_win", DW'(rd[WORD_W-1:0]), DW'(115));
        held = rd;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 9'd7; bus.req_stride = '0;
        bus.req_mask = 16'h0001; bus.req_wdata = DW'(999);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_hold", bus.rsp_rdata, held);
            check("stall_ready", DW'(bus.req_ready), DW'(0));
        end
        #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        do_req(0, 7, 0, 16'h0001, '0, rd, ok, er);
        check("stall_ignored", DW'(rd[WORD_W-1:0]), DW'(115));

        for (int c = 0; c < 400; c++) begin
            bus.req_valid  = ($urandom_range(0, 9) < 7);
            bus.req_we     = $urandom_range(0, 1) == 1;
            bus.req_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
            bus.req_stride = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 40));
            bus.req_mask   = LANES'($urandom);
            for (int i = 0; i < LANES; i++) bus.req_wdata[WORD_W*i +: WORD_W] = $urandom;
            bus.rsp_ready  = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;

        bus.rsp_ready = 1'b0;
        do_req(0, 0, 1, 16'hFFFF, '0, rd, ok, er);
        for (int i = 0; i < LANES; i++) wd[WORD_W*i +: WORD_W] = 32'h5;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = '0; bus.req_stride = 9'd1;
        bus.req_mask = 16'hFFFF; bus.req_wdata = wd;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", DW'(bus.rsp_valid), DW'(0));
        check("mid_rst_done", DW'(bus.init_done), DW'(0));
        reset = 1'b0;
        bus.req_valid = 1'b0;
        wait_init("reinit_latency");
        for (int b = 0; b < DEPTH; b += LANES) begin
            do_req(0, b, 1, 16'hFFFF, '0, rd, ok, er);
            check("reinit_zero", rd, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
